// File: rtl/gain_ctrlport_responder_pkg.sv
// Shared register map, ctrlport types and FSM state for the gain ctrlport responder.
package gain_regs_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned STS_W  = 2;
    localparam int unsigned OFFS_W = 6;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ERR_W  = 8;

    localparam logic [OFFS_W-1:0] REG_GAIN_PEND   = 6'h00;
    localparam logic [OFFS_W-1:0] REG_GAIN_ACTIVE = 6'h04;
    localparam logic [OFFS_W-1:0] REG_STATUS      = 6'h08;
    localparam logic [OFFS_W-1:0] REG_ERR_CLR     = 6'h0C;

    typedef enum logic [STS_W-1:0] {
        STS_OKAY   = 2'd0,
        STS_CMDERR = 2'd1
    } ctrl_status_e;

    typedef struct packed {
        ctrl_status_e        status;
        logic [DATA_W-1:0]   data;
    } ctrl_resp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/gain_ctrlport_responder_if.sv
// Ctrlport request/response bundle between the endpoint and the responder.
interface gain_ctrlport_responder_if;
    import gain_regs_pkg::*;

    logic              req_wr;
    logic              req_rd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [BE_W-1:0]   req_byte_en;
    logic              resp_ack;
    logic [STS_W-1:0]  resp_status;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_wr, req_rd, req_addr, req_data, req_byte_en,
        input  resp_ack, resp_status, resp_data
    );

    modport slave (
        input  req_wr, req_rd, req_addr, req_data, req_byte_en,
        output resp_ack, resp_status, resp_data
    );

endinterface

// File: rtl/gain_ctrlport_responder_axis_pkt_tracker.sv
// Tracks packet framing on the observed stream and flags edges where a gain change is safe.
module axis_pkt_tracker (
    input  logic clk,
    input  logic rst,
    input  logic axis_tvalid,
    input  logic axis_tready,
    input  logic axis_tlast,
    output logic commit_ok_c
);

    logic hs_c;
    logic in_pkt;

    assign hs_c = axis_tvalid & axis_tready;

    // Inside a packet between its first non-last beat and its last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt <= 1'b0;
        end else if (hs_c) begin
            in_pkt <= ~axis_tlast;
        end
    end

    // Safe unless a packet is open or one is starting on this edge.
    assign commit_ok_c = ~in_pkt & ~(hs_c & ~axis_tlast);

endmodule

// File: rtl/gain_ctrlport_responder.sv
// Ctrlport register responder for the gain block; commits gain at packet boundaries.
module gain_ctrlport_responder
    import gain_regs_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 20'h0,
    parameter int unsigned       RESP_LATENCY = 1,
    parameter int unsigned       GAIN_W       = 16,
    parameter logic [31:0]       RESET_GAIN   = 32'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    gain_ctrlport_responder_if.slave s_ctrlport,
    input  logic                 axis_tvalid,
    input  logic                 axis_tready,
    input  logic                 axis_tlast,
    output logic [GAIN_W-1:0]    gain_active,
    output logic                 pending
);

    localparam logic [GAIN_W-1:0] RST_GAIN = GAIN_W'(RESET_GAIN);
    localparam logic [CNT_W-1:0]  LAT_M1   = CNT_W'(RESP_LATENCY - 1);

    fsm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_resp_t        hold_q, hold_d;
    ctrl_resp_t        resp_q, resp_d;
    logic              ack_q, ack_d;
    logic [GAIN_W-1:0] gain_pend_q, gain_pend_d;
    logic [GAIN_W-1:0] gain_active_q, gain_active_d;
    logic              pending_q, pending_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              commit_ok_c;
    logic              hit_c, req_c, accept_c, drop_c;
    logic [OFFS_W-1:0] offs_c;
    ctrl_resp_t        dec_c;
    logic              wr_pend_c, wr_clr_c;
    logic [DATA_W-1:0] pend_merge_c;
    logic              unused_merge;

    axis_pkt_tracker u_pkt_tracker (
        .clk         (clk),
        .rst         (rst),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tlast  (axis_tlast),
        .commit_ok_c (commit_ok_c)
    );

    assign offs_c   = s_ctrlport.req_addr[OFFS_W-1:0];
    assign hit_c    = s_ctrlport.req_addr[ADDR_W-1:OFFS_W] == BASE_ADDR[ADDR_W-1:OFFS_W];
    assign req_c    = (s_ctrlport.req_wr | s_ctrlport.req_rd) & hit_c;
    assign accept_c = req_c & (state_q == ST_IDLE);
    assign drop_c   = req_c & (state_q == ST_BUSY);

    // Decode the current request into its response and write strobes.
    always_comb begin
        dec_c     = '{status: STS_OKAY, data: '0};
        wr_pend_c = 1'b0;
        wr_clr_c  = 1'b0;
        if (s_ctrlport.req_wr && s_ctrlport.req_rd) begin
            dec_c.status = STS_CMDERR;
        end else if (s_ctrlport.req_rd) begin
            case (offs_c)
                REG_GAIN_PEND:   dec_c.data = DATA_W'(gain_pend_q);
                REG_GAIN_ACTIVE: dec_c.data = DATA_W'(gain_active_q);
                REG_STATUS:      dec_c.data = {16'h0, err_cnt_q, 7'h0, pending_q};
                REG_ERR_CLR:     dec_c.data = '0;
                default:         dec_c.status = STS_CMDERR;
            endcase
        end else begin
            case (offs_c)
                REG_GAIN_PEND: wr_pend_c = 1'b1;
                REG_ERR_CLR:   wr_clr_c  = 1'b1;
                default:       dec_c.status = STS_CMDERR;
            endcase
        end
    end

    // Byte-enable merge of write data onto the pending gain.
    always_comb begin
        pend_merge_c = DATA_W'(gain_pend_q);
        for (int i = 0; i < int'(BE_W); i++) begin
            if (s_ctrlport.req_byte_en[i]) begin
                pend_merge_c[8*i +: 8] = s_ctrlport.req_data[8*i +: 8];
            end
        end
    end

    assign unused_merge = ^pend_merge_c;

    // Next-state, register effects and registered response outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        ack_d         = 1'b0;
        resp_d        = '{status: STS_OKAY, data: '0};
        gain_pend_d   = gain_pend_q;
        gain_active_d = gain_active_q;
        pending_d     = pending_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT_M1;
                    hold_d  = dec_c;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_BUSY && cnt_d == '0) begin
            ack_d  = 1'b1;
            resp_d = hold_d;
        end

        if (drop_c && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if (accept_c && wr_clr_c) begin
            err_cnt_d = '0;
        end

        // Commit takes the pre-write value; a same-edge write keeps pending set.
        if (pending_q && commit_ok_c) begin
            gain_active_d = gain_pend_q;
            pending_d     = 1'b0;
        end
        if (accept_c && wr_pend_c) begin
            gain_pend_d = GAIN_W'(pend_merge_c);
            pending_d   = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hold_q        <= '{status: STS_OKAY, data: '0};
            resp_q        <= '{status: STS_OKAY, data: '0};
            ack_q         <= 1'b0;
            gain_pend_q   <= RST_GAIN;
            gain_active_q <= RST_GAIN;
            pending_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            resp_q        <= resp_d;
            ack_q         <= ack_d;
            gain_pend_q   <= gain_pend_d;
            gain_active_q <= gain_active_d;
            pending_q     <= pending_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign s_ctrlport.resp_ack    = ack_q;
    assign s_ctrlport.resp_status = resp_q.status;
    assign s_ctrlport.resp_data   = resp_q.data;
    assign gain_active            = gain_active_q;
    assign pending                = pending_q;

endmodule

// File: tb/tb_gain_ctrlport_responder.sv
// Scoreboard bench for the gain ctrlport responder: directed requests and stream framing.
module tb_gain_ctrlport_responder;

    localparam int unsigned LAT    = 3;
    localparam logic [19:0] BASE   = 20'h01240;
    localparam logic [1:0]  OK     = 2'd0;
    localparam logic [1:0]  CMDERR = 2'd1;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  sts;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        axis_tvalid, axis_tready, axis_tlast;
    logic [15:0] gain_active;
    logic        pending;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        e;

    gain_ctrlport_responder_if cp ();

    gain_ctrlport_responder #(
        .BASE_ADDR    (BASE),
        .RESP_LATENCY (LAT),
        .GAIN_W       (16),
        .RESET_GAIN   (32'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_ctrlport  (cp),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tlast  (axis_tlast),
        .gain_active (gain_active),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack must match the oldest expected response and its cycle.
    always @(negedge clk) begin
        if (cp.resp_ack) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: cyc %0d status %0d data %h", cyc, cp.resp_status, cp.resp_data);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || cp.resp_status !== e.sts || cp.resp_data !== e.data) begin
                    errors++;
                    $display("FAIL resp: got cyc %0d status %0d data %h, expected cyc %0d status %0d data %h",
                             cyc, cp.resp_status, cp.resp_data, e.cyc, e.sts, e.data);
                end
            end
        end else begin
            checks++;
            if (cp.resp_status !== 2'd0 || cp.resp_data !== 32'd0) begin
                errors++;
                $display("FAIL idle_resp: status %0d data %h with ack low, expected 0", cp.resp_status, cp.resp_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request for the current cycle; leaves the bench one cycle later.
    task automatic issue(input logic wr, input logic rd, input logic [19:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         input bit expect_ack, input logic [1:0] sts, input logic [31:0] edata);
        exp_t x;
        cp.req_wr      = wr;
        cp.req_rd      = rd;
        cp.req_addr    = addr;
        cp.req_data    = data;
        cp.req_byte_en = be;
        if (expect_ack) begin
            x.cyc  = cyc + LAT;
            x.sts  = sts;
            x.data = edata;
            q.push_back(x);
        end
        tick(1);
        cp.req_wr = 1'b0;
        cp.req_rd = 1'b0;
    endtask

    task automatic rd(input logic [5:0] offs, input logic [1:0] sts, input logic [31:0] edata);
        issue(1'b0, 1'b1, BASE + 20'(offs), 32'd0, 4'h0, 1'b1, sts, edata);
        tick(LAT);
    endtask

    task automatic wr(input logic [5:0] offs, input logic [31:0] data, input logic [3:0] be,
                      input logic [1:0] sts);
        issue(1'b1, 1'b0, BASE + 20'(offs), data, be, 1'b1, sts, 32'd0);
        tick(LAT);
    endtask

    task automatic beat(input logic v, input logic l);
        axis_tvalid = v;
        axis_tready = v;
        axis_tlast  = l;
    endtask

    initial begin
        rst = 1'b1;
        cp.req_wr = 1'b0; cp.req_rd = 1'b0; cp.req_addr = '0; cp.req_data = '0; cp.req_byte_en = '0;
        beat(1'b0, 1'b0);
        tick(3);
        chk("rst_gain_active", 32'(gain_active), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);
        rst = 1'b0;
        tick(1);

        // Reset value read, ack after exactly LAT cycles
        rd(6'h04, OK, 32'h1);

        // Idle-stream write commits on the next edge
        issue(1'b1, 1'b0, BASE, 32'h1234, 4'hF, 1'b1, OK, 32'h0);
        chk("wr_pending_set", 32'(pending), 32'h1);
        chk("wr_active_old", 32'(gain_active), 32'h1);
        tick(1);
        chk("commit_active", 32'(gain_active), 32'h1234);
        chk("commit_pending_clr", 32'(pending), 32'h0);
        tick(2);
        rd(6'h08, OK, 32'h0);
        rd(6'h00, OK, 32'h1234);

        // 5-beat packet with a write after beat 2
        beat(1'b1, 1'b0);
        tick(2);
        beat(1'b0, 1'b0);
        issue(1'b1, 1'b0, BASE, 32'h0200, 4'hF, 1'b1, OK, 32'h0);
        chk("pkt_pending", 32'(pending), 32'h1);
        beat(1'b1, 1'b0);
        chk("pkt_b3_gain", 32'(gain_active), 32'h1234);
        tick(1);
        chk("pkt_b4_gain", 32'(gain_active), 32'h1234);
        tick(1);
        beat(1'b1, 1'b1);
        chk("pkt_b5_gain", 32'(gain_active), 32'h1234);
        tick(1);
        beat(1'b0, 1'b0);
        tick(1);
        chk("pkt_commit_gain", 32'(gain_active), 32'h0200);
        chk("pkt_commit_pending", 32'(pending), 32'h0);
        beat(1'b1, 1'b1);
        chk("next_pkt_gain", 32'(gain_active), 32'h0200);
        tick(1);
        beat(1'b0, 1'b0);

        // Byte-enabled write onto 0x1234
        wr(6'h00, 32'h1234, 4'hF, OK);
        wr(6'h00, 32'h0000AB00, 4'b0010, OK);
        rd(6'h00, OK, 32'hAB34);
        rd(6'h04, OK, 32'hAB34);

        // Back-to-back requests: second dropped, err_cnt counts it
        issue(1'b0, 1'b1, BASE + 20'h08, 32'd0, 4'h0, 1'b1, OK, 32'h0);
        issue(1'b0, 1'b1, BASE + 20'h08, 32'd0, 4'h0, 1'b0, OK, 32'h0);
        tick(LAT - 1);
        rd(6'h08, OK, 32'h100);
        wr(6'h0C, 32'hDEAD, 4'hF, OK);
        rd(6'h08, OK, 32'h0);
        rd(6'h10, CMDERR, 32'h0);
        wr(6'h04, 32'h5, 4'hF, CMDERR);
        issue(1'b1, 1'b1, BASE, 32'hFFFF, 4'hF, 1'b1, CMDERR, 32'h0);
        tick(LAT);
        chk("both_no_pending", 32'(pending), 32'h0);
        rd(6'h00, OK, 32'hAB34);
        issue(1'b0, 1'b1, 20'h00004, 32'd0, 4'h0, 1'b0, OK, 32'h0);
        tick(LAT + 1);
        rd(6'h08, OK, 32'h0);

        // Reset while busy and mid-packet
        beat(1'b1, 1'b0);
        issue(1'b1, 1'b0, BASE, 32'h5555, 4'hF, 1'b0, OK, 32'h0);
        chk("pre_rst_pending", 32'(pending), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_gain", 32'(gain_active), 32'h1);
        chk("rst_mid_pending", 32'(pending), 32'h0);
        beat(1'b0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(LAT + 1);
        rd(6'h04, OK, 32'h1);
        rd(6'h00, OK, 32'h1);
        issue(1'b1, 1'b0, BASE, 32'h0077, 4'hF, 1'b1, OK, 32'h0);
        chk("post_rst_pending", 32'(pending), 32'h1);
        tick(1);
        chk("post_rst_commit", 32'(gain_active), 32'h0077);
        tick(LAT);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL ack_timeout: %0d responses outstanding, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
